// File: rtl/adder_pkg.sv
// Shared types for the adder result path: the result word with its
// precomputed status flags and the FIFO occupancy encoding.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } add_flags_t;

    typedef struct packed {
        logic [ADDER_WIDTH-1:0] sum;
        add_flags_t             flags;
    } add_result_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Flags are fixed at capture time so the output side never re-derives them.
    function automatic add_result_t make_result(
        input logic [ADDER_WIDTH-1:0] sum,
        input logic                   cout,
        input logic                   of
    );
        add_result_t r;
        r.sum         = sum;
        r.flags.zero  = (sum == '0);
        r.flags.neg   = sum[ADDER_WIDTH-1];
        r.flags.carry = cout;
        r.flags.ovf   = of;
        return r;
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry valid/ready FIFO of add_result_t. Ready depends only on
// registered occupancy, so there is no combinational path from pop to push.
module result_fifo2
    import adder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  add_result_t data_i,
    output logic        ready_o,
    input  logic        pop_i,
    output logic        valid_o,
    output add_result_t data_o,
    output logic        accept_o
);

    occ_e        occ_q, occ_d;
    add_result_t head_q, head_d;
    add_result_t tail_q, tail_d;
    logic        push;
    logic        pop;

    assign push     = push_i && (occ_q != OCC_FULL) && !rst;
    assign pop      = pop_i && (occ_q != OCC_EMPTY);
    assign accept_o = push;

    // Held low during reset so upstream cannot believe a word was taken.
    assign ready_o = !rst && (occ_q != OCC_FULL);
    assign valid_o = (occ_q != OCC_EMPTY);
    assign data_o  = valid_o ? head_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // Simultaneous push and pop replaces the head in place.
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    tail_d = data_i;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage behind the ripple adder: flag capture, a 2-entry
// result buffer, and sticky/saturating overflow statistics for the harness.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_in,
    input  logic             cout_in,
    input  logic             of_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_ovf,
    input  logic             clr_stats,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    add_result_t in_word;
    add_result_t head_word;
    logic        accepted;
    logic        ovf_event;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign in_word = make_result(s_in, cout_in, of_in);

    result_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (in_valid),
        .data_i   (in_word),
        .ready_o  (in_ready),
        .pop_i    (out_ready),
        .valid_o  (out_valid),
        .data_o   (head_word),
        .accept_o (accepted)
    );

    assign result     = head_word.sum;
    assign flag_zero  = head_word.flags.zero;
    assign flag_neg   = head_word.flags.neg;
    assign flag_carry = head_word.flags.carry;
    assign flag_ovf   = head_word.flags.ovf;

    assign ovf_event = accepted && of_in;

    // An overflow event in the same cycle as a clear wins: the clear drops the
    // history and the new event is counted as the first.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (ovf_event) begin
            sticky_d = 1'b1;
            if (clr_stats) begin
                count_d = CNT_W'(1);
            end else if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (clr_stats) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage; expected values are hand-computed.
// The counter is built 4 bits wide so saturation is reachable quickly.
module tb_adder_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sIn;
    logic             coutIn;
    logic             ofIn;
    logic             inValid;
    logic             inReady;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             flagZero;
    logic             flagNeg;
    logic             flagCarry;
    logic             flagOvf;
    logic             clrStats;
    logic             ovfSticky;
    logic [CNT_W-1:0] ovfCount;

    int vectorCount = 0;
    int missCount   = 0;

    adder_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (sIn),
        .cout_in    (coutIn),
        .of_in      (ofIn),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .result     (result),
        .flag_zero  (flagZero),
        .flag_neg   (flagNeg),
        .flag_carry (flagCarry),
        .flag_ovf   (flagOvf),
        .clr_stats  (clrStats),
        .ovf_sticky (ovfSticky),
        .ovf_count  (ovfCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] s,
                                 input logic cout, input logic of,
                                 input logic ready, input logic clr);
        inValid  = valid;
        sIn      = s;
        coutIn   = cout;
        ofIn     = of;
        outReady = ready;
        clrStats = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst in_ready", 32'(inReady), 32'd0);
        checkOutput("rst out_valid", 32'(outValid), 32'd0);
        checkOutput("rst result", result, 32'd0);
        checkOutput("rst ovf_count", 32'(ovfCount), 32'd0);
        checkOutput("rst ovf_sticky", 32'(ovfSticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-rst in_ready", 32'(inReady), 32'd1);

        // Single push of zero sum with carry out.
        applyStimulus(1, 32'h0000_0000, 1, 0, 0, 0);
        tick();
        checkOutput("single out_valid", 32'(outValid), 32'd1);
        checkOutput("single result", result, 32'h0);
        checkOutput("single zero", 32'(flagZero), 32'd1);
        checkOutput("single carry", 32'(flagCarry), 32'd1);
        checkOutput("single neg", 32'(flagNeg), 32'd0);
        checkOutput("single ovf", 32'(flagOvf), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        tick();
        checkOutput("drain out_valid", 32'(outValid), 32'd0);
        checkOutput("idle result", result, 32'd0);
        checkOutput("idle zero", 32'(flagZero), 32'd0);
        checkOutput("idle carry", 32'(flagCarry), 32'd0);

        // Streaming with out_ready high.
        applyStimulus(1, 32'h7FFF_FFFF, 0, 0, 1, 0);
        tick();
        checkOutput("stream0 result", result, 32'h7FFF_FFFF);
        checkOutput("stream0 neg", 32'(flagNeg), 32'd0);
        checkOutput("stream0 count", 32'(ovfCount), 32'd0);
        applyStimulus(1, 32'h8000_0000, 1, 1, 1, 0);
        tick();
        checkOutput("stream1 result", result, 32'h8000_0000);
        checkOutput("stream1 neg", 32'(flagNeg), 32'd1);
        checkOutput("stream1 ovf", 32'(flagOvf), 32'd1);
        checkOutput("stream1 count", 32'(ovfCount), 32'd1);
        checkOutput("stream1 sticky", 32'(ovfSticky), 32'd1);
        applyStimulus(1, 32'h1234_5678, 0, 0, 1, 0);
        tick();
        checkOutput("stream2 result", result, 32'h1234_5678);
        checkOutput("stream2 neg", 32'(flagNeg), 32'd0);
        checkOutput("stream2 zero", 32'(flagZero), 32'd0);
        checkOutput("stream2 count", 32'(ovfCount), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        tick();
        checkOutput("stream end out_valid", 32'(outValid), 32'd0);

        // Backpressure: two accepted, third held while FULL.
        applyStimulus(1, 32'hA000_0001, 0, 0, 0, 0);
        checkOutput("bp0 in_ready", 32'(inReady), 32'd1);
        tick();
        applyStimulus(1, 32'hA000_0002, 0, 0, 0, 0);
        checkOutput("bp1 in_ready", 32'(inReady), 32'd1);
        tick();
        checkOutput("bp full in_ready", 32'(inReady), 32'd0);
        applyStimulus(1, 32'hA000_0003, 0, 1, 0, 0);
        tick();
        checkOutput("bp hold result", result, 32'hA000_0001);
        checkOutput("bp blocked count", 32'(ovfCount), 32'd1);
        checkOutput("bp still full", 32'(inReady), 32'd0);
        outReady = 1'b1;
        tick();
        checkOutput("bp pop1 result", result, 32'hA000_0002);
        checkOutput("bp pop1 in_ready", 32'(inReady), 32'd1);
        checkOutput("bp pop1 count", 32'(ovfCount), 32'd1);
        tick();
        checkOutput("bp third result", result, 32'hA000_0003);
        checkOutput("bp third ovf", 32'(flagOvf), 32'd1);
        checkOutput("bp third count", 32'(ovfCount), 32'd2);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        tick();
        checkOutput("bp drained", 32'(outValid), 32'd0);

        // Push+pop while holding one entry.
        applyStimulus(1, 32'h0000_00AA, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h0000_00BB, 0, 0, 1, 0);
        tick();
        checkOutput("pp head", result, 32'h0000_00BB);
        checkOutput("pp in_ready", 32'(inReady), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        tick();
        checkOutput("pp hold", result, 32'h0000_00BB);
        checkOutput("pp hold valid", 32'(outValid), 32'd1);
        outReady = 1'b1;
        tick();
        checkOutput("pp empty", 32'(outValid), 32'd0);

        // Saturating counter and clear interaction.
        applyStimulus(0, 32'h0, 0, 0, 1, 1);
        tick();
        checkOutput("clr count", 32'(ovfCount), 32'd0);
        checkOutput("clr sticky", 32'(ovfSticky), 32'd0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 32'(i + 1), 0, 1, 1, 0);
            tick();
        end
        checkOutput("sat count", 32'(ovfCount), 32'd15);
        checkOutput("sat last result", result, 32'd17);
        applyStimulus(1, 32'h0000_C0DE, 0, 1, 1, 1);
        tick();
        checkOutput("clr+ovf count", 32'(ovfCount), 32'd1);
        checkOutput("clr+ovf sticky", 32'(ovfSticky), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 1, 1);
        tick();
        checkOutput("clr alone count", 32'(ovfCount), 32'd0);
        checkOutput("clr alone sticky", 32'(ovfSticky), 32'd0);

        // Reset while FULL with count 5.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h5000_0000 + 32'(i), 0, 1, 1, 0);
            tick();
        end
        applyStimulus(1, 32'h5000_0004, 0, 1, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("pre-rst count", 32'(ovfCount), 32'd5);
        checkOutput("pre-rst full", 32'(inReady), 32'd0);
        checkOutput("pre-rst head", result, 32'h5000_0003);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid-rst out_valid", 32'(outValid), 32'd0);
        checkOutput("mid-rst count", 32'(ovfCount), 32'd0);
        checkOutput("mid-rst sticky", 32'(ovfSticky), 32'd0);
        checkOutput("mid-rst in_ready", 32'(inReady), 32'd0);
        checkOutput("mid-rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel in_ready", 32'(inReady), 32'd1);
        tick();
        checkOutput("rel empty", 32'(outValid), 32'd0);
        applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("rel push result", result, 32'hFFFF_FFFF);
        checkOutput("rel push neg", 32'(flagNeg), 32'd1);
        checkOutput("rel push in_ready", 32'(inReady), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
# adder_result_stage

Registered output stage directly downstream of the 32-bit ripple adder. Captures the adder's sum, carry-out and overflow, derives status flags, and buffers results in a 2-entry valid/ready FIFO so the combinational adder path is isolated between flops for timing measurement. Also keeps a sticky overflow flag and a saturating overflow-event counter for the test harness.

## Interface
- `WIDTH`, 32, adder datapath width (sum bits).
- `CNT_W`, 16, width of the overflow-event counter.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `s_in` input WIDTH: adder sum S.
- `cout_in` input 1: adder Cout.
- `of_in` input 1: adder OF (signed overflow).
- `in_valid` input 1: upstream presents a valid result this cycle.
- `in_ready` output 1: stage can accept a result this cycle.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes head this cycle.
- `result` output WIDTH: head sum.
- `flag_zero` output 1: head sum == 0.
- `flag_neg` output 1: head sum MSB.
- `flag_carry` output 1: head Cout.
- `flag_ovf` output 1: head OF.
- `clr_stats` input 1: synchronous clear of sticky flag and counter.
- `ovf_sticky` output 1: set once any accepted word had OF=1.
- `ovf_count` output CNT_W: number of accepted words with OF=1, saturating.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- Flags are computed from `s_in`/`cout_in`/`of_in` at push time and stored with the entry; they are not recomputed at the output.
- FIFO holds 2 entries; occupancy states are EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push → ONE.
  - ONE: push only → FULL; pop only → EMPTY; push+pop → ONE, with the new entry becoming head on the next cycle.
  - FULL: `in_ready`=0 and a push is impossible; pop → ONE.
- `in_ready` = (occupancy != FULL), derived from registered occupancy only; it never depends on `out_ready` (no combinational pass-through).
- Entries leave in push order. Head outputs hold stable while `out_valid && !out_ready`.
- Output fields when `out_valid`=0: `result`=0 and all flags 0.
- Statistics: an accepted word (push) with `of_in`=1 sets `ovf_sticky` and increments `ovf_count`. The counter saturates at 2^CNT_W−1 and does not wrap.
- `clr_stats` zeroes both statistics. If `clr_stats` coincides with an OF push, the result is `ovf_sticky`=1 and `ovf_count`=1 (event wins over clear).
- Statistics count accepted words only; a word offered while `in_ready`=0 is not counted.

## Timing
- Latency: a word pushed at edge N appears at the outputs with `out_valid`=1 after edge N (one cycle). There is no same-cycle input→output path.
- Full throughput of 1 word/cycle when `out_ready` is held high.
- Reset (asynchronous, immediate):
  - occupancy EMPTY; `out_valid`=0; `result`=0; all flags 0; `ovf_sticky`=0; `ovf_count`=0.
  - `in_ready`=0 while `rst` is high; `in_ready`=1 from the first cycle after deassertion.
- Reset mid-operation discards all buffered entries and statistics. No partial state survives.
- Statistic outputs update on the edge following the push, together with the entry.

## Structure
- Shared package `adder_pkg`:
  - `ADDER_WIDTH`=32 constant.
  - packed struct `add_flags_t` {zero, neg, carry, ovf}.
  - packed struct `add_result_t` {sum[ADDER_WIDTH-1:0], add_flags_t}.
- Sub-module `result_fifo2`: generic 2-entry valid/ready FIFO of `add_result_t`.
- Top level contains flag derivation at the input plus the statistics logic.

## Test plan
- Reset then single push: `s_in`=0x0000_0000, `cout_in`=1, `of_in`=0 → next cycle `out_valid`=1, `result`=0, `flag_zero`=1, `flag_carry`=1, `flag_neg`=0.
- Streaming with `out_ready`=1: pushes 0x7FFF_FFFF(OF=0), 0x8000_0000(OF=1), 0x1234_5678 on consecutive cycles → identical sequence out, each one cycle later; `flag_neg`=1 on the 2nd only; `ovf_count`=1, `ovf_sticky`=1.
- Backpressure: `out_ready`=0, three consecutive pushes → first two accepted, `in_ready`=0 after the 2nd; third offer is held by upstream; raise `out_ready` → order preserved, third accepted once `in_ready`=1.
- Push+pop while ONE: occupancy stays ONE; head advances to the new word next cycle; no loss or duplicate.
- Counter: CNT_W=4, 17 OF pushes → `ovf_count`=15 (saturated). Then `clr_stats` together with an OF push → `ovf_count`=1, `ovf_sticky`=1. Then `clr_stats` alone → 0, 0.
- Assert `rst` with FULL FIFO and `ovf_count`=5 → immediately `out_valid`=0, `ovf_count`=0, `in_ready`=0. After release, `in_ready`=1 and the FIFO is empty.
